// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode/operand-fetch stage (OPFETCH_BYPASS_EN: forward writebacks instead of retrying)
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  output logic        rf_ren1,
  output logic        rf_ren2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_wen,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd
);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

`ifdef OPFETCH_BYPASS_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID, S_RETRY} state_t;
`endif

  // Unknown opcodes fall back to the I layout (rs1 only).
  function automatic fmt_t decode_fmt(input logic [6:0] op);
    case (op)
      7'b0110011: return FMT_R;
      7'b0100011: return FMT_S;
      7'b1100011: return FMT_B;
      7'b0110111: return FMT_U;
      7'b0010111: return FMT_U;
      7'b1101111: return FMT_J;
      default:    return FMT_I;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] i);
    logic [31:0] imm;
    imm = '0;
    case (decode_fmt(i[6:0]))
      FMT_I:   imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {i[31:12], 12'b0};
      FMT_J:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic        in_idle;
  logic [6:0]  cur_op;
  fmt_t        cur_fmt;
  logic        fmt_use1;
  logic        fmt_use2;
  logic        use1_nz;
  logic        use2_nz;
  logic        wb_hit1;
  logic        wb_hit2;
  logic        issue;
  logic        w0_hit1_q;
  logic        w0_hit2_q;
  logic [31:0] cap1;
  logic [31:0] cap2;

`ifdef OPFETCH_BYPASS_EN
  logic [31:0] w0_data1_q;
  logic [31:0] w0_data2_q;
`else
  logic        stall;
  // Write data is never consumed here: hazards are resolved by re-reading the register file.
  logic        unused_wdata;
  assign unused_wdata = ^wb_wdata;
`endif

  // In IDLE the read ports follow the offered instruction; afterwards they follow the latched one.
  assign in_idle   = (state_q == S_IDLE);
  assign cur_op    = in_idle ? in_inst[6:0]   : out_inst[6:0];
  assign rf_raddr1 = in_idle ? in_inst[19:15] : out_inst[19:15];
  assign rf_raddr2 = in_idle ? in_inst[24:20] : out_inst[24:20];
  assign cur_fmt   = decode_fmt(cur_op);
  assign fmt_use1  = (cur_fmt != FMT_U) && (cur_fmt != FMT_J);
  assign fmt_use2  = (cur_fmt == FMT_R) || (cur_fmt == FMT_S) || (cur_fmt == FMT_B);
  assign use1_nz   = fmt_use1 && (rf_raddr1 != 5'd0);
  assign use2_nz   = fmt_use2 && (rf_raddr2 != 5'd0);

  // Same expression serves as the W0 check in an issue cycle and the W1 check in READ.
  assign wb_hit1   = wb_wen && use1_nz && (wb_waddr == rf_raddr1);
  assign wb_hit2   = wb_wen && use2_nz && (wb_waddr == rf_raddr2);

`ifdef OPFETCH_BYPASS_EN
  assign issue     = in_idle && in_valid;
`else
  assign issue     = (in_idle && in_valid) || (state_q == S_RETRY);
`endif

  assign rf_ren1   = rst_n && issue && fmt_use1;
  assign rf_ren2   = rst_n && issue && fmt_use2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_READ;
      end
      S_READ: begin
`ifdef OPFETCH_BYPASS_EN
        state_d = S_VALID;
`else
        state_d = stall ? S_RETRY : S_VALID;
`endif
      end
      S_VALID: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
`ifndef OPFETCH_BYPASS_EN
      S_RETRY: state_d = S_READ;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Remember writebacks that hit a source in the cycle the reads were issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_hit1_q  <= 1'b0;
      w0_hit2_q  <= 1'b0;
`ifdef OPFETCH_BYPASS_EN
      w0_data1_q <= '0;
      w0_data2_q <= '0;
`endif
    end else if (issue) begin
      w0_hit1_q  <= wb_hit1;
      w0_hit2_q  <= wb_hit2;
`ifdef OPFETCH_BYPASS_EN
      w0_data1_q <= wb_wdata;
      w0_data2_q <= wb_wdata;
`endif
    end
  end

  // Operand selection in READ; the later (W1) writeback takes priority over the earlier one
  always_comb begin
    cap1 = '0;
    cap2 = '0;
`ifdef OPFETCH_BYPASS_EN
    if (use1_nz) cap1 = wb_hit1 ? wb_wdata : (w0_hit1_q ? w0_data1_q : rf_rdata1);
    if (use2_nz) cap2 = wb_hit2 ? wb_wdata : (w0_hit2_q ? w0_data2_q : rf_rdata2);
`else
    stall = wb_hit1 || wb_hit2 || w0_hit1_q || w0_hit2_q;
    if (use1_nz) cap1 = rf_rdata1;
    if (use2_nz) cap2 = rf_rdata2;
`endif
  end

  // Latch instruction fields on accept and operands on the READ to VALID transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc      <= '0;
      out_inst    <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
    end else begin
      if (in_idle && in_valid) begin
        out_pc   <= in_pc;
        out_inst <= in_inst;
        out_imm  <= gen_imm(in_inst);
        out_rd   <= in_inst[11:7];
      end
      if ((state_q == S_READ) && (state_d == S_VALID)) begin
        out_rs1_val <= cap1;
        out_rs2_val <= cap2;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic        rf_ren1, rf_ren2;
  logic [31:0] rf_rdata1 = '0;
  logic [31:0] rf_rdata2 = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd)
  );

`ifdef OPFETCH_BYPASS_EN
  localparam int HZ_LAT = 2;
`else
  localparam int HZ_LAT = 4;
`endif

  // Register file: synchronous read, a write at an edge is not seen by a read at that edge
  logic [31:0] rf_mem [0:31];
  always @(posedge clk) begin
    if (rf_ren1) rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : rf_mem[rf_raddr1];
    if (rf_ren2) rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : rf_mem[rf_raddr2];
    if (wb_wen && wb_waddr != 5'd0) rf_mem[wb_waddr] <= wb_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  bit          lg_wen  [0:63];
  logic [4:0]  lg_addr [0:63];
  bit          sc_wen  [0:7];
  logic [4:0]  sc_addr [0:7];
  logic [31:0] sc_data [0:7];

  int          last_lat;
  logic [31:0] last_rs1, last_rs2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    bit          u1;
    bit          u2;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf_mem[idx];
  endfunction

  function automatic bit src_hit(input int c, input bit u1, input bit u2,
                                 input logic [4:0] s1, input logic [4:0] s2);
    return lg_wen[c] && ((u1 && s1 != 5'd0 && lg_addr[c] == s1) ||
                         (u2 && s2 != 5'd0 && lg_addr[c] == s2));
  endfunction

  // Latency from accept to first out_valid: fixed with forwarding, else every window with a hit costs two cycles
  function automatic int model_lat(input bit u1, input bit u2, input logic [4:0] s1, input logic [4:0] s2);
    int t;
    int lat_retry;
    t = 0;
    lat_retry = -2;
    while (t < 60) begin
      if (src_hit(t, u1, u2, s1, s2) || src_hit(t + 1, u1, u2, s1, s2)) t += 2;
      else begin
        lat_retry = t + 2;
        break;
      end
    end
`ifdef OPFETCH_BYPASS_EN
    return 2;
`else
    return lat_retry;
`endif
  endfunction

  task automatic drive_wb(input int mode, input int idx, input logic [31:0] inst);
    int sel;
    wb_wen = 1'b0;
    if (mode == 1 && idx <= 10) begin
      wb_wen = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 3);
      wb_waddr = (sel == 0) ? inst[19:15] : (sel == 1) ? inst[24:20] :
                 (sel == 2) ? 5'($urandom_range(0, 31)) : 5'd0;
      wb_wdata = $urandom;
    end else if (mode == 2 && idx < 8) begin
      wb_wen   = sc_wen[idx];
      wb_waddr = sc_addr[idx];
      wb_wdata = sc_data[idx];
    end
    if (idx < 64) begin
      lg_wen[idx]  = wb_wen;
      lg_addr[idx] = wb_waddr;
    end
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
    @(negedge clk);
    wb_wen = 1'b0;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 8; i++) begin
      sc_wen[i] = 1'b0; sc_addr[i] = '0; sc_data[i] = '0;
    end
  endtask

  // One instruction through the stage; mode 0 no writebacks, 1 random, 2 scripted
  task automatic issue(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] e_imm, input logic [4:0] e_rd, input bit u1, input bit u2,
                       input int mode, input int hold);
    int v;
    logic [31:0] e1, e2;
    logic [4:0] s1, s2;
    s1 = inst[19:15];
    s2 = inst[24:20];
    for (int i = 0; i < 64; i++) begin lg_wen[i] = 1'b0; lg_addr[i] = '0; end
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = (hold == 0);
    drive_wb(mode, 0, inst);
    #1;
    check({tag, ".in_ready_A"}, 32'(in_ready), 32'd1);
    check({tag, ".ren1"}, 32'(rf_ren1), 32'(u1));
    check({tag, ".ren2"}, 32'(rf_ren2), 32'(u2));
    check({tag, ".raddr1"}, 32'(rf_raddr1), 32'(s1));
    check({tag, ".raddr2"}, 32'(rf_raddr2), 32'(s2));
    v = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid = 1'b0; in_inst = $urandom; in_pc = $urandom;
      drive_wb(mode, c, inst);
      #1;
      if (out_valid) begin v = c; break; end
    end
    last_lat = v;
    check({tag, ".latency"}, 32'(v), 32'(model_lat(u1, u2, s1, s2)));
    if (v < 0) begin
      wb_wen = 1'b0;
      return;
    end
    e1 = u1 ? ref_val(s1) : 32'd0;
    e2 = u2 ? ref_val(s2) : 32'd0;
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".inst"}, out_inst, inst);
    check({tag, ".imm"}, out_imm, e_imm);
    check({tag, ".rd"}, 32'(out_rd), 32'(e_rd));
    check({tag, ".rs1"}, out_rs1_val, e1);
    check({tag, ".rs2"}, out_rs2_val, e2);
    last_rs1 = out_rs1_val;
    last_rs2 = out_rs2_val;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      out_ready = (k == hold);
      drive_wb(mode, v + k, inst);
      #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_ren"}, 32'({rf_ren1, rf_ren2}), 32'd0);
      check({tag, ".hold_rs1"}, out_rs1_val, e1);
      check({tag, ".hold_rs2"}, out_rs2_val, e2);
      check({tag, ".hold_imm"}, out_imm, e_imm);
      check({tag, ".hold_pc"}, out_pc, pc);
    end
    @(negedge clk);
    out_ready = 1'b0; wb_wen = 1'b0;
    #1;
    check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    int cls;
    logic [31:0] inst, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  op;
    bit          u1, u2;
    int          iv;

    tbl[0] = '{32'hFFD08293, 32'hFFFFFFFD, 5'd5,  1'b1, 1'b0};
    tbl[1] = '{32'hFF9FF0EF, 32'hFFFFFFF8, 5'd1,  1'b0, 1'b0};
    tbl[2] = '{32'h123454B7, 32'h12345000, 5'd9,  1'b0, 1'b0};
    tbl[3] = '{32'h002083B3, 32'h00000000, 5'd7,  1'b1, 1'b1};
    tbl[4] = '{32'h0021A423, 32'h00000008, 5'd8,  1'b1, 1'b1};
    tbl[5] = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd29, 1'b1, 1'b1};
    tbl[6] = '{32'hFFFFF197, 32'hFFFFF000, 5'd3,  1'b0, 1'b0};
    tbl[7] = '{32'h8000A07F, 32'hFFFFF800, 5'd0,  1'b1, 1'b0};
    tbl[8] = '{32'hFFF32203, 32'hFFFFFFFF, 5'd4,  1'b1, 1'b0};
    tbl[9] = '{32'h00000073, 32'h00000000, 5'd0,  1'b1, 1'b0};
    clear_script();
    last_rs1 = '0; last_rs2 = '0; last_lat = 0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.ren", 32'({rf_ren1, rf_ren2}), 32'd0);
    check("reset.out_pc", out_pc, 32'd0);
    check("reset.out_inst", out_inst, 32'd0);
    check("reset.out_imm", out_imm, 32'd0);
    check("reset.out_rs1", out_rs1_val, 32'd0);
    check("reset.out_rs2", out_rs2_val, 32'd0);
    check("reset.out_rd", 32'(out_rd), 32'd0);

    for (int r = 1; r < 32; r++) rf_write(5'(r), 32'h01010101 * r);
    rf_write(5'd1, 32'h10);

    for (int i = 0; i < 10; i++)
      issue($sformatf("tbl%0d", i), tbl[i].inst, 32'h1000 + 4 * i, tbl[i].imm, tbl[i].rd,
            tbl[i].u1, tbl[i].u2, 0, 0);

    issue("addi", 32'hFFD08293, 32'h2000, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0, 0, 0);
    check("addi.rs1_hand", last_rs1, 32'h10);
    check("addi.lat_hand", 32'(last_lat), 32'd2);

    clear_script();
    for (int k = 2; k < 6; k++) begin sc_wen[k] = 1'b1; sc_addr[k] = 5'd3; sc_data[k] = 32'hDEAD0000 + k; end
    issue("sw_bp", 32'h0021A423, 32'h2004, 32'h8, 5'd8, 1'b1, 1'b1, 2, 5);
    check("sw_bp.rs1_hand", last_rs1, 32'h03030303);

    clear_script();
    sc_wen[0] = 1'b1; sc_addr[0] = 5'd1; sc_data[0] = 32'hAA;
    issue("w0", 32'h002083B3, 32'h2008, 32'h0, 5'd7, 1'b1, 1'b1, 2, 0);
    check("w0.rs1_hand", last_rs1, 32'hAA);
    check("w0.lat_hand", 32'(last_lat), 32'(HZ_LAT));

    clear_script();
    sc_wen[0] = 1'b1; sc_addr[0] = 5'd2; sc_data[0] = 32'h11;
    sc_wen[1] = 1'b1; sc_addr[1] = 5'd2; sc_data[1] = 32'h22;
    issue("w0w1", 32'h002083B3, 32'h200C, 32'h0, 5'd7, 1'b1, 1'b1, 2, 0);
    check("w0w1.rs2_hand", last_rs2, 32'h22);
    check("w0w1.lat_hand", 32'(last_lat), 32'(HZ_LAT));

    clear_script();
    sc_wen[0] = 1'b1; sc_addr[0] = 5'd0; sc_data[0] = 32'h55;
    sc_wen[1] = 1'b1; sc_addr[1] = 5'd9; sc_data[1] = 32'h66;
    issue("lui", 32'h123454B7, 32'h2010, 32'h12345000, 5'd9, 1'b0, 1'b0, 2, 0);
    check("lui.lat_hand", 32'(last_lat), 32'd2);
    check("lui.rs_hand", last_rs1 | last_rs2, 32'd0);

    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'hFFD08293; in_pc = 32'h3000;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    check("rst_mid.ren", 32'({rf_ren1, rf_ren2}), 32'd0);
    check("rst_mid.out_inst", out_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      seen += int'(out_valid);
    end
    check("rst_mid.no_bundle", 32'(seen), 32'd0);

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 6);
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      u1 = 1'b1; u2 = 1'b0; imm = '0;
      case (cls)
        0: begin
          inst = {7'($urandom_range(0, 127)), rs2, rs1, f3, rd, 7'b0110011};
          u2 = 1'b1;
        end
        1, 6: begin
          iv = int'($urandom_range(0, 4095)) - 2048;
          imm = 32'(iv);
          case ($urandom_range(0, 4))
            0: op = 7'b0010011;
            1: op = 7'b0000011;
            2: op = 7'b1100111;
            3: op = 7'b1110011;
            default: op = 7'b0001111;
          endcase
          inst = {imm[11:0], rs1, f3, rd, op};
        end
        2: begin
          iv = int'($urandom_range(0, 4095)) - 2048;
          imm = 32'(iv);
          inst = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
          u2 = 1'b1;
        end
        3: begin
          iv = 2 * (int'($urandom_range(0, 4095)) - 2048);
          imm = 32'(iv);
          inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
          u2 = 1'b1;
        end
        4: begin
          imm = $urandom & 32'hFFFFF000;
          op = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111;
          inst = {imm[31:12], rd, op};
          u1 = 1'b0;
        end
        default: begin
          iv = 2 * (int'($urandom_range(0, 1048575)) - 524288);
          imm = 32'(iv);
          inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
          u1 = 1'b0;
        end
      endcase
      issue($sformatf("rnd%0d", n), inst, $urandom, imm, inst[11:7], u1, u2, 1, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
